// File: rtl/cool_heat_pkg.sv
// Shared types and constants for the cool/heat sequencing controller.
// Holds the FSM state encoding, fan thresholds and PWM step.
package cool_heat_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEATING = 2'd1,
    COOLING = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0] FAN_T1     = 8'd40;
  localparam logic [7:0] FAN_T2     = 8'd45;
  localparam logic [7:0] PWM_STEP   = 8'd64;
  localparam logic [7:0] RESET_TEMP = 8'd25;

  function automatic logic [7:0] pwm_duty(logic [1:0] lvl);
    return 8'(lvl) * PWM_STEP;
  endfunction

endpackage

// File: rtl/cool_heat_controller_pwm.sv
// Free-running 8-bit up counter that times the fan PWM period.
// Wraps 255 -> 0 and is never gated by the controller FSM.
module pwm_counter (
  input  logic       clk,
  input  logic       arst,
  output logic [7:0] count
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb count_d = count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (arst) count_q <= 8'd0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cool_heat_controller.sv
// Hysteresis heat/cool sequencer with post-run hold-off and a
// PWM-driven cooler fan whose speed tracks the sampled temperature.
module cool_heat_controller
  import cool_heat_pkg::*;
#(
  parameter logic [7:0] HEAT_ON  = 8'd15,
  parameter logic [7:0] HEAT_OFF = 8'd25,
  parameter logic [7:0] COOL_ON  = 8'd35,
  parameter logic [7:0] COOL_OFF = 8'd25,
  parameter logic [7:0] DWELL    = 8'd16
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] temperature,
  input  logic       temp_valid,
  output logic       heater_on,
  output logic       cooler_on,
  output logic [1:0] fan_level,
  output logic       fan_pwm,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [7:0] temp_q, temp_d;
  logic [7:0] dwell_q, dwell_d;
  logic [1:0] fan_q, fan_d;
  logic [7:0] pwm_cnt;

  pwm_counter u_pwm (
    .clk   (clk),
    .arst  (arst),
    .count (pwm_cnt)
  );

  always_comb temp_d = temp_valid ? temperature : temp_q;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (temp_q < HEAT_ON)      state_d = HEATING;
        else if (temp_q > COOL_ON) state_d = COOLING;
      end
      HEATING: begin
        if (temp_q >= HEAT_OFF) begin
          state_d = HOLDOFF;
          dwell_d = DWELL - 8'd1;
        end
      end
      COOLING: begin
        if (temp_q <= COOL_OFF) begin
          state_d = HOLDOFF;
          dwell_d = DWELL - 8'd1;
        end
      end
      HOLDOFF: begin
        if (dwell_q == 8'd0) state_d = IDLE;
        else                 dwell_d = dwell_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Cooling speed is registered, so it trails entry into COOLING by a cycle.
  always_comb begin
    fan_d = 2'd0;
    if (state_q == COOLING) begin
      unique case (1'b1)
        (temp_q <= FAN_T1):                     fan_d = 2'd1;
        (temp_q > FAN_T1 && temp_q <= FAN_T2):  fan_d = 2'd2;
        (temp_q > FAN_T2):                      fan_d = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      temp_q  <= RESET_TEMP;
      dwell_q <= 8'd0;
      fan_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      dwell_q <= dwell_d;
      fan_q   <= fan_d;
    end
  end

  always_comb begin
    fan_level = 2'd0;
    case (state_q)
      HEATING: fan_level = 2'd1;
      COOLING: fan_level = fan_q;
      default: fan_level = 2'd0;
    endcase
  end

  assign heater_on = (state_q == HEATING);
  assign cooler_on = (state_q == COOLING);
  assign busy      = (state_q != IDLE);
  assign fan_pwm   = (pwm_cnt < pwm_duty(fan_level));

endmodule

// File: tb/tb_cool_heat_controller.sv
// Randomized and directed bench for cool_heat_controller against a
// cycle-level behavioural model of the heat/cool/hold-off rules.
module tb_cool_heat_controller;

  localparam int HEAT_ON  = 15;
  localparam int HEAT_OFF = 25;
  localparam int COOL_ON  = 35;
  localparam int COOL_OFF = 25;
  localparam int DWELL    = 16;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [7:0] temperature = 8'd25;
  logic       temp_valid = 1'b0;
  logic       heater_on;
  logic       cooler_on;
  logic [1:0] fan_level;
  logic       fan_pwm;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 heat, 2 cool, 3 hold-off
  int m_mode = 0;
  int m_temp = 25;
  int m_left = 0;
  int m_tick = 0;
  int m_speed = 0;

  cool_heat_controller dut (
    .clk         (clk),
    .arst        (arst),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .heater_on   (heater_on),
    .cooler_on   (cooler_on),
    .fan_level   (fan_level),
    .fan_pwm     (fan_pwm),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int speed_of(int t);
    if (t <= 40) return 1;
    if (t <= 45) return 2;
    return 3;
  endfunction

  task automatic model_edge();
    int nxt_speed;
    if (arst) begin
      m_mode  = 0;
      m_temp  = 25;
      m_left  = 0;
      m_tick  = 0;
      m_speed = 0;
      return;
    end
    nxt_speed = (m_mode == 2) ? speed_of(m_temp) : 0;
    if (m_mode == 0) begin
      if (m_temp < HEAT_ON)      m_mode = 1;
      else if (m_temp > COOL_ON) m_mode = 2;
    end else if (m_mode == 1) begin
      if (m_temp >= HEAT_OFF) begin m_mode = 3; m_left = DWELL; end
    end else if (m_mode == 2) begin
      if (m_temp <= COOL_OFF) begin m_mode = 3; m_left = DWELL; end
    end else begin
      if (m_left == 1) m_mode = 0;
      else m_left = m_left - 1;
    end
    if (temp_valid) m_temp = int'(temperature);
    m_tick  = (m_tick + 1) % 256;
    m_speed = nxt_speed;
  endtask

  task automatic step();
    logic [5:0] exp_v;
    int         fl;
    @(posedge clk);
    model_edge();
    #1;
    fl = (m_mode == 1) ? 1 : (m_mode == 2) ? m_speed : 0;
    exp_v = {m_mode == 1, m_mode == 2, 2'(fl),
             m_tick < fl * 64, m_mode != 0};
    chk("outs", {heater_on, cooler_on, fan_level, fan_pwm, busy}, exp_v);
  endtask

  task automatic drive(input logic r, input int t, input logic v,
                       input int n);
    arst        = r;
    temperature = 8'(t);
    temp_valid  = v;
    repeat (n) step();
  endtask

  initial begin
    int cnt;

    drive(1, 25, 1, 3);
    chk("rst_heat", heater_on, 0);
    chk("rst_cool", cooler_on, 0);
    chk("rst_fan", fan_level, 0);
    chk("rst_pwm", fan_pwm, 0);
    chk("rst_busy", busy, 0);
    drive(0, 25, 1, 300);
    chk("idle_busy", busy, 0);

    drive(0, 10, 1, 2);
    chk("heat_on", heater_on, 1);
    chk("heat_fan", fan_level, 1);
    drive(0, 24, 1, 10);
    chk("heat_hold", heater_on, 1);
    drive(0, 25, 1, 1);
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy) cnt++;
    end
    chk("hold_len", cnt, DWELL + 1);

    drive(0, 38, 1, 3);
    chk("cool_on", cooler_on, 1);
    chk("cool_l1", fan_level, 1);
    drive(0, 43, 1, 2);
    chk("cool_l2", fan_level, 2);
    drive(0, 50, 1, 2);
    chk("cool_l3", fan_level, 3);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (fan_pwm) cnt++;
    end
    chk("duty3", cnt, 192);

    drive(0, 25, 1, 1);
    cnt = 0;
    temperature = 8'd50;
    for (int i = 0; i < DWELL + 1; i++) begin
      step();
      if (cooler_on) cnt++;
    end
    chk("hold_block", cnt, 0);
    drive(0, 50, 1, 2);
    chk("restart", cooler_on, 1);

    drive(0, 50, 1, 5);
    chk("pre_rst_l3", fan_level, 3);
    drive(1, 50, 1, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pwm", fan_pwm, 0);
    chk("mid_rst_cool", cooler_on, 0);
    drive(0, 25, 1, 2);
    chk("no_holdoff", busy, 0);

    drive(0, 5, 0, 20);
    chk("gate_off", heater_on, 0);
    drive(0, 5, 1, 1);
    drive(0, 5, 0, 1);
    chk("gate_heat", heater_on, 1);

    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic v;
      int   t;
      int   n;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 2) == 0);
      t = $urandom_range(0, 60);
      n = $urandom_range(1, 8);
      drive(r, t, v, r ? 1 : n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
